// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags,
// synchronous flush and a selectable first-word-fall-through read mode.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        d_in,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        d_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Thresholds sized to the count register so the flag compares are width-matched.
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_full;
  logic              w_empty;
  logic              w_wrAccept;
  logic              w_rdAccept;

  // Flags are pure decodes of the registered count; no extra flag state exists.
  assign w_full       = (r_count == DEPTH_C);
  assign w_empty      = (r_count == '0);
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AF_C);
  assign almost_empty = (r_count <= AE_C);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Acceptance is judged on the pre-edge state, so at full a simultaneous
  // read is taken while the write is dropped, and the reverse at empty.
  assign w_wrAccept = wr_en && !w_full;
  assign w_rdAccept = rd_en && !w_empty;

  // Storage array; it is never reset or flushed, only the pointers are.
  always_ff @(posedge clk) begin
    if (!flush && w_wrAccept) begin
      r_mem[r_wrPtr] <= d_in;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_wrAccept) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_rdAccept) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
    end
  end

  // Occupancy moves only when exactly one side is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      unique case ({w_wrAccept, w_rdAccept})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags: set on any rejected request, cleared only by reset or flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is visible combinationally; zero while nothing is stored.
      always_comb begin
        d_out = w_empty ? '0 : r_mem[r_rdPtr];
      end
    end else begin : g_std
      logic [DATA_W-1:0] r_dOut;

      // Registered read: the head word is captured on the edge that accepts the read.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_dOut <= '0;
        end else if (!flush && w_rdAccept) begin
          r_dOut <= r_mem[r_rdPtr];
        end
      end

      assign d_out = r_dOut;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: one standard-read and one FWFT instance share the same
// stimulus and are compared against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DEPTH = 16;
  localparam int AFT   = DEPTH - 2;
  localparam int AET   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       wrEn = 1'b0;
  logic       rdEn = 1'b0;
  logic [7:0] dIn = 8'h00;

  logic [7:0] dOutS, dOutF;
  logic       fullS, fullF, emptyS, emptyF;
  logic       afS, afF, aeS, aeF;
  logic [4:0] countS, countF;
  logic       ovfS, ovfF, udfS, udfF;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] model[$];
  bit         mOvf = 1'b0;
  bit         mUdf = 1'b0;
  logic [7:0] mOutS = 8'h00;

  sync_fifo_param #(.DATA_W(8), .DEPTH(DEPTH), .AF_THRESH(AFT), .AE_THRESH(AET), .FWFT(0)) uStd (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wrEn), .d_in(dIn), .rd_en(rdEn),
    .d_out(dOutS), .full(fullS), .empty(emptyS), .almost_full(afS), .almost_empty(aeS),
    .count(countS), .overflow(ovfS), .underflow(udfS)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(DEPTH), .AF_THRESH(AFT), .AE_THRESH(AET), .FWFT(1)) uFwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wrEn), .d_in(dIn), .rd_en(rdEn),
    .d_out(dOutF), .full(fullF), .empty(emptyF), .almost_full(afF), .almost_empty(aeF),
    .count(countF), .overflow(ovfF), .underflow(udfF)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares every output of both instances against the reference model.
  task automatic checkOutput(input string tag);
    int n;
    logic [7:0] head;
    n = model.size();
    head = (n > 0) ? model[0] : 8'h00;
    checkVal({tag, "/countS"}, 32'(countS), n);
    checkVal({tag, "/countF"}, 32'(countF), n);
    checkVal({tag, "/fullS"},  32'(fullS),  32'(n == DEPTH));
    checkVal({tag, "/fullF"},  32'(fullF),  32'(n == DEPTH));
    checkVal({tag, "/emptyS"}, 32'(emptyS), 32'(n == 0));
    checkVal({tag, "/emptyF"}, 32'(emptyF), 32'(n == 0));
    checkVal({tag, "/afS"},    32'(afS),    32'(n >= AFT));
    checkVal({tag, "/afF"},    32'(afF),    32'(n >= AFT));
    checkVal({tag, "/aeS"},    32'(aeS),    32'(n <= AET));
    checkVal({tag, "/aeF"},    32'(aeF),    32'(n <= AET));
    checkVal({tag, "/ovfS"},   32'(ovfS),   32'(mOvf));
    checkVal({tag, "/ovfF"},   32'(ovfF),   32'(mOvf));
    checkVal({tag, "/udfS"},   32'(udfS),   32'(mUdf));
    checkVal({tag, "/udfF"},   32'(udfF),   32'(mUdf));
    checkVal({tag, "/doutS"},  32'(dOutS),  32'(mOutS));
    checkVal({tag, "/doutF"},  32'(dOutF),  32'(head));
  endtask

  // Drives one cycle of requests and advances the reference model at the edge.
  task automatic applyStimulus(input bit w, input bit r, input bit f, input logic [7:0] d);
    int n;
    wrEn = w;
    rdEn = r;
    flush = f;
    dIn = d;
    @(posedge clk);
    n = model.size();
    if (f) begin
      model.delete();
      mOvf = 1'b0;
      mUdf = 1'b0;
    end else begin
      if (w && n == DEPTH) mOvf = 1'b1;
      if (r && n == 0) mUdf = 1'b1;
      if (r && n > 0) mOutS = model.pop_front();
      if (w && n < DEPTH) model.push_back(d);
    end
    #1;
    wrEn = 1'b0;
    rdEn = 1'b0;
    flush = 1'b0;
  endtask

  task automatic modelReset();
    model.delete();
    mOvf = 1'b0;
    mUdf = 1'b0;
    mOutS = 8'h00;
  endtask

  initial begin
    // Reset values while rst is held low, before any clock edge
    #1;
    checkOutput("reset");
    #3;
    rst = 1'b1;

    // Fill to full; almost_full first rises at 14
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'($urandom));
      checkOutput("fill");
    end
    checkVal("full16", 32'(fullS), 32'd1);

    // Write while full is dropped and sets overflow
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hEE);
    checkOutput("overflow");
    checkVal("ovfSet", 32'(ovfS), 32'd1);

    // Drain in order
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput("drain");
    end

    // Reads while empty set underflow, d_out holds
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput("underflow");
    end

    // Streaming 40 words across the pointer wrap twice
    for (int i = 0; i < 43; i++) begin
      applyStimulus(i < 40, i >= 3, 1'b0, 8'($urandom));
      checkOutput("stream");
    end

    // Simultaneous requests at count 5
    while (model.size() < 5) applyStimulus(1'b1, 1'b0, 1'b0, 8'($urandom));
    applyStimulus(1'b1, 1'b1, 1'b0, 8'($urandom));
    checkOutput("both@5");
    checkVal("count5", 32'(countS), 32'd5);

    // Simultaneous requests at full
    while (model.size() < DEPTH) applyStimulus(1'b1, 1'b0, 1'b0, 8'($urandom));
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h77);
    checkOutput("both@full");
    checkVal("count15", 32'(countS), 32'd15);

    // Simultaneous requests at empty
    while (model.size() > 0) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h5A);
    checkOutput("both@empty");
    checkVal("count1", 32'(countS), 32'd1);

    // Flush with a concurrent write at count 9 while overflow is set
    while (model.size() < 9) applyStimulus(1'b1, 1'b0, 1'b0, 8'($urandom));
    checkVal("ovfBeforeFlush", 32'(ovfS), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h99);
    checkOutput("flush");
    checkVal("emptyAfterFlush", 32'(emptyS), 32'd1);

    // FWFT head appears right after the write edge
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hA5);
    checkOutput("fwftWrite");
    checkVal("fwftA5", 32'(dOutF), 32'hA5);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("fwftPop");
    checkVal("fwftZero", 32'(dOutF), 32'h00);

    // Random traffic with occasional flush
    for (int i = 0; i < 200; i++) begin
      applyStimulus($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                    $urandom_range(0, 99) < 2, 8'($urandom));
      checkOutput("random");
    end

    // Asynchronous reset mid-stream at count 7, checked between edges
    while (model.size() < 7) applyStimulus(1'b1, 1'b0, 1'b0, 8'($urandom));
    while (model.size() > 7) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    #2;
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput("asyncReset");
    #1;
    rst = 1'b1;

    // First write after reset lands at the head
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h3C);
    checkOutput("postReset");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("postResetRead");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
